alu_nibble_sequencer: RTL
=========================

Name: alu_nibble_sequencer

Overview:
- Upstream/downstream companion of alu_4bit: runs a wide operation (4*NIBBLES bits) through the single combinational 4-bit ALU, one nibble per clock, LSB nibble first.
- Drives the ALU's a, b, cin, s_op; captures its z and cout each cycle; chains cout into the next nibble's cin.
- Accepts commands on a valid/ready input handshake.
- Returns the assembled result and final carry on a valid/ready output handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; legal range 2..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_op  in  2  ALU operation code, forwarded unchanged to s_op.
- in_cin  in  1  carry into nibble 0.
- alu_a  out  4  to alu_4bit a.
- alu_b  out  4  to alu_4bit b.
- alu_cin  out  1  to alu_4bit cin.
- alu_s_op  out  2  to alu_4bit s_op.
- alu_z  in  4  from alu_4bit z.
- alu_cout  in  1  from alu_4bit cout.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts result.
- res  out  W  assembled result.
- res_cout  out  1  alu_cout captured on the last nibble.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - in_ready=1 (once rst_n released).
  - res_valid=0, res=0, res_cout=0, busy=0.
  - alu_a=0, alu_b=0, alu_cin=0, alu_s_op=2'b00.
  - Nibble counter=0; all operand and carry registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at a clock edge: latch in_a, in_b, in_op, in_cin; counter<=0; go to RUN.
- RUN (in_ready=0):
  - Combinational ALU drive: alu_a=a_reg[4*cnt+:4], alu_b=b_reg[4*cnt+:4], alu_s_op=op_reg, alu_cin=carry_reg.
  - carry_reg is initialised to the latched in_cin.
  - Each edge: res[4*cnt+:4]<=alu_z; carry_reg<=alu_cout; cnt<=cnt+1.
  - When cnt==NIBBLES-1 the same edge also loads res_cout<=alu_cout and moves to DONE.
  - Exactly NIBBLES cycles in RUN. Accept-to-res_valid latency = NIBBLES+1 edges; res_valid rises on the edge after the last nibble.
- Carry chaining applies to every op; the ALU ignores cin for its non-arithmetic ops.
- Outside RUN: alu_a=0, alu_b=0, alu_cin=0; alu_s_op holds op_reg.
- DONE:
  - res_valid=1; res and res_cout held stable until the handshake completes.
  - On res_valid&res_ready: res_valid<=0, go to IDLE. res keeps its value; in_ready rises the next cycle.
  - No same-cycle re-accept.
- in_valid while busy: ignored, no side effects; the upstream must hold it until in_ready.
- Counter width: clog2(NIBBLES); never exceeds NIBBLES-1; no wrap beyond the last nibble.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded; no res_valid is produced for the aborted command.
- ALU encoding used by the team: s_op=2'b10 is ADD (z,cout = a+b+cin).

Test Plan:
- ADD, NIBBLES=4: in_a=16'h1234, in_b=16'h0FFF, in_cin=0 -> res=16'h2233, res_cout=0; res_valid asserted exactly 5 edges after accept.
- Carry ripple: in_a=16'hFFFF, in_b=16'h0001, cin=0 -> alu_cin sequence 0,1,1,1; res=16'h0000, res_cout=1.
- Carry-in: in_a=16'h0000, in_b=16'h0000, in_cin=1 -> res=16'h0001, res_cout=0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res and res_cout stable, in_ready=0, a pulsing in_valid is ignored; then res_ready=1 -> IDLE next edge, and the next command completes correctly.
- Reset mid-op: rst_n low after nibble 1 of 16'hFFFF+16'h0001 -> all outputs immediately at reset values; no res_valid; a fresh 16'h0001+16'h0001 gives 16'h0002.
- Back-to-back: two commands issued with in_valid held high and res_ready=1 -> two results in order; no command lost or duplicated.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// alu_nibble_sequencer
//   Runs a 4*NIBBLES-bit operation through an external combinational 4-bit
//   ALU (alu_4bit), one nibble per clock, LSB nibble first. The carry out of
//   each nibble is chained into the carry in of the next one.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   in_valid/in_ready     : command handshake
//   in_a, in_b            : W-bit operands
//   in_op                 : ALU op code, forwarded to alu_s_op
//   in_cin                : carry into nibble 0
//   alu_a/alu_b/alu_cin   : nibble operands and carry driven to the ALU
//   alu_s_op              : op code driven to the ALU
//   alu_z/alu_cout        : ALU nibble result and carry out
//   res_valid/res_ready   : result handshake
//   res, res_cout         : assembled result and carry out of the last nibble
//   busy                  : high while an operation is running or waiting
//                           for its result to be taken
// ---------------------------------------------------------------------------
module alu_nibble_sequencer #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4*NIBBLES,
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic [1:0]   in_op,
   input  logic         in_cin,
   output logic [3:0]   alu_a,
   output logic [3:0]   alu_b,
   output logic         alu_cin,
   output logic [1:0]   alu_s_op,
   input  logic [3:0]   alu_z,
   input  logic         alu_cout,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res,
   output logic         res_cout,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [W-1:0]    r_a;
   logic [W-1:0]    r_b;
   logic [1:0]      r_op;
   logic            r_carry;
   logic [W-1:0]    r_res;
   logic            r_res_cout;
   logic            r_in_ready;
   logic            r_res_valid;
   logic            r_busy;

   logic            w_run;
   logic            w_last;
   logic [W-1:0]    w_a_sh;
   logic [W-1:0]    w_b_sh;

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_cnt == CW'(NIBBLES-1));

   // Current nibble brought down to bit 0 by shifting 4*cnt.
   assign w_a_sh = r_a >> {r_cnt, 2'b00};
   assign w_b_sh = r_b >> {r_cnt, 2'b00};

   // ALU operands are only driven while running; op code is always visible.
   assign alu_a    = w_run ? w_a_sh[3:0] : 4'h0;
   assign alu_b    = w_run ? w_b_sh[3:0] : 4'h0;
   assign alu_cin  = w_run ? r_carry     : 1'b0;
   assign alu_s_op = r_op;

   assign in_ready  = r_in_ready;
   assign res_valid = r_res_valid;
   assign res       = r_res;
   assign res_cout  = r_res_cout;
   assign busy      = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= 2'b00;
         r_carry     <= 1'b0;
         r_res       <= '0;
         r_res_cout  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_res_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_op       <= in_op;
                  r_carry    <= in_cin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               for (int i = 0; i < NIBBLES; i++) begin
                  if (r_cnt == CW'(i)) r_res[4*i +: 4] <= alu_z;
               end
               r_carry <= alu_cout;
               // Counter parks on the last nibble; it is cleared on accept.
               if (w_last) begin
                  r_res_cout  <= alu_cout;
                  r_res_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               // Ready only returns the cycle after the result is taken,
               // so a command is never accepted in the handshake cycle.
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
